// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: RV32I memory stage holding the EX/MEM register and a load/store unit.
//    Inputs from execute (*E) are captured into the M register when the stage advances.
//    HoldM freezes M, and FlushM turns the next advancing edge into a bubble.
//    Register outputs (*M) feed forwarding and writeback.
//    ReadDataM is the extended load data, and StallMem goes to the hazard unit.
//    dmem_* is a valid/ready data-memory bus with a word address, replicated data and byte strobes.
//    misaligned_fault flags a trapped misaligned access.
//    Optional macro LSU_MISALIGN_TRAP_EN traps misaligned accesses instead of force-aligning them.
module mem_stage_lsu #(
   parameter int XLEN     = 32,
   parameter int ADDR_LSB = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [XLEN-1:0] ALUResultE,
   input  logic [XLEN-1:0] WriteDataE,
   input  logic [2:0]      funct3E,
   input  logic            MemReadE,
   input  logic            MemWriteE,
   input  logic            RegWriteE,
   input  logic [4:0]      RdE,
   input  logic [1:0]      ResultSrcE,
   input  logic [XLEN-1:0] PCPlus4E,
   input  logic            HoldM,
   input  logic            FlushM,
   output logic [XLEN-1:0] ALUResultM,
   output logic            RegWriteM,
   output logic [4:0]      RdM,
   output logic [1:0]      ResultSrcM,
   output logic [XLEN-1:0] PCPlus4M,
   output logic [XLEN-1:0] ReadDataM,
   output logic            StallMem,
   output logic            dmem_req,
   output logic            dmem_we,
   output logic [XLEN-1:0] dmem_addr,
   output logic [XLEN-1:0] dmem_wdata,
   output logic [3:0]      dmem_wstrb,
   input  logic            dmem_ready,
   input  logic [XLEN-1:0] dmem_rdata,
   output logic            misaligned_fault
);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t          state_q, state_d;
   logic [XLEN-1:0] alu_result_q, alu_result_d;
   logic [XLEN-1:0] write_data_q, write_data_d;
   logic [2:0]      funct3_q, funct3_d;
   logic            mem_read_q, mem_read_d;
   logic            mem_write_q, mem_write_d;
   logic            reg_write_q, reg_write_d;
   logic [4:0]      rd_q, rd_d;
   logic [1:0]      result_src_q, result_src_d;
   logic [XLEN-1:0] pc_plus4_q, pc_plus4_d;
   logic [XLEN-1:0] rdata_q, rdata_d;
   logic            memop, fault, hs, advance, is_byte, is_half, sign;
   logic [1:0]      off, off_eff;
   logic [7:0]      ld_byte;
   logic [15:0]     ld_half;
   logic [XLEN-1:0] ext;
`ifdef LSU_MISALIGN_TRAP_EN
   logic            misalign;
`endif
   always_comb begin
      memop   = mem_read_q | mem_write_q;
      off     = alu_result_q[1:0];
      is_byte = funct3_q[1:0] == 2'b00;
      is_half = funct3_q[1:0] == 2'b01;
      sign    = !funct3_q[2];
`ifdef LSU_MISALIGN_TRAP_EN
      misalign = is_half ? off[0] : (!is_byte && off != 2'b00);
      fault    = memop & misalign;
      off_eff  = off;
`else
      fault    = 1'b0;
      off_eff  = is_byte ? off : is_half ? {off[1], 1'b0} : 2'b00;
`endif
      // DONE means the data already arrived under HoldM, so the bus stays quiet.
      dmem_req   = memop & !fault & (state_q != DONE);
      hs         = dmem_req & dmem_ready;
      StallMem   = dmem_req & !dmem_ready;
      advance    = !StallMem & !HoldM;
      dmem_we    = dmem_req & mem_write_q;
      dmem_addr  = {alu_result_q[XLEN-1:ADDR_LSB], {ADDR_LSB{1'b0}}};
      dmem_wdata = is_byte ? {4{write_data_q[7:0]}} : is_half ? {2{write_data_q[15:0]}} : write_data_q;
      dmem_wstrb = !dmem_we ? 4'b0000 : is_byte ? 4'b0001 << off_eff : is_half ? 4'b0011 << off_eff : 4'b1111;
      ld_byte    = off_eff[1] ? (off_eff[0] ? dmem_rdata[31:24] : dmem_rdata[23:16])
                              : (off_eff[0] ? dmem_rdata[15:8]  : dmem_rdata[7:0]);
      ld_half    = off_eff[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      ext        = is_byte ? {{24{sign & ld_byte[7]}}, ld_byte}
                 : is_half ? {{16{sign & ld_half[15]}}, ld_half} : dmem_rdata;
      ReadDataM  = !mem_read_q ? '0 : state_q == DONE ? rdata_q : ext;
      misaligned_fault = fault;
      ALUResultM = alu_result_q;
      RegWriteM  = reg_write_q & !fault;
      RdM        = rd_q;
      ResultSrcM = result_src_q;
      PCPlus4M   = pc_plus4_q;
      state_d    = state_q == DONE ? (HoldM ? DONE : IDLE)
                 : hs ? (HoldM ? DONE : IDLE) : dmem_req ? BUSY : IDLE;
      rdata_d    = (hs & HoldM) ? ext : rdata_q;
      alu_result_d = !advance ? alu_result_q : FlushM ? '0 : ALUResultE;
      write_data_d = !advance ? write_data_q : FlushM ? '0 : WriteDataE;
      funct3_d     = !advance ? funct3_q     : FlushM ? '0 : funct3E;
      mem_read_d   = !advance ? mem_read_q   : !FlushM & MemReadE;
      mem_write_d  = !advance ? mem_write_q  : !FlushM & MemWriteE;
      reg_write_d  = !advance ? reg_write_q  : !FlushM & RegWriteE;
      rd_d         = !advance ? rd_q         : FlushM ? '0 : RdE;
      result_src_d = !advance ? result_src_q : FlushM ? '0 : ResultSrcE;
      pc_plus4_d   = !advance ? pc_plus4_q   : FlushM ? '0 : PCPlus4E;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         rdata_q      <= '0;
         alu_result_q <= '0;
         write_data_q <= '0;
         funct3_q     <= '0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         reg_write_q  <= 1'b0;
         rd_q         <= '0;
         result_src_q <= '0;
         pc_plus4_q   <= '0;
      end else begin
         state_q      <= state_d;
         rdata_q      <= rdata_d;
         alu_result_q <= alu_result_d;
         write_data_q <= write_data_d;
         funct3_q     <= funct3_d;
         mem_read_q   <= mem_read_d;
         mem_write_q  <= mem_write_d;
         reg_write_q  <= reg_write_d;
         rd_q         <= rd_d;
         result_src_q <= result_src_d;
         pc_plus4_q   <= pc_plus4_d;
      end
   end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: scoreboard bench for mem_stage_lsu bus transactions, load extension and pipeline control.
module tb_mem_stage_lsu;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic [31:0] ALUResultE = '0, WriteDataE = '0, PCPlus4E = '0, dmem_rdata = '0;
   logic [2:0]  funct3E = '0;
   logic        MemReadE = 1'b0, MemWriteE = 1'b0, RegWriteE = 1'b0, HoldM = 1'b0, FlushM = 1'b0, dmem_ready = 1'b0;
   logic [4:0]  RdE = '0;
   logic [1:0]  ResultSrcE = '0;
   logic [31:0] ALUResultM, PCPlus4M, ReadDataM, dmem_addr, dmem_wdata;
   logic        RegWriteM, StallMem, dmem_req, dmem_we, misaligned_fault;
   logic [4:0]  RdM;
   logic [1:0]  ResultSrcM;
   logic [3:0]  dmem_wstrb;
   int checks = 0, failures = 0;
   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  strb;
      logic [31:0] wdata;
      logic        rdchk;
      logic [31:0] rdexp;
   } exp_t;
   exp_t sb[$];

   mem_stage_lsu dut (
      .clk(clk), .rst_n(rst_n), .ALUResultE(ALUResultE), .WriteDataE(WriteDataE), .funct3E(funct3E),
      .MemReadE(MemReadE), .MemWriteE(MemWriteE), .RegWriteE(RegWriteE), .RdE(RdE), .ResultSrcE(ResultSrcE),
      .PCPlus4E(PCPlus4E), .HoldM(HoldM), .FlushM(FlushM), .ALUResultM(ALUResultM), .RegWriteM(RegWriteM),
      .RdM(RdM), .ResultSrcM(ResultSrcM), .PCPlus4M(PCPlus4M), .ReadDataM(ReadDataM), .StallMem(StallMem),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_wstrb(dmem_wstrb), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata), .misaligned_fault(misaligned_fault)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic mr, input logic mw, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
      MemReadE = mr; MemWriteE = mw; funct3E = f3; ALUResultE = a; WriteDataE = wd;
      RegWriteE = mr; RdE = mr ? 5'd3 : 5'd0; ResultSrcE = mr ? 2'd1 : 2'd0; PCPlus4E = a + 32'd4;
   endtask

   task automatic bubble();
      drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      PCPlus4E = '0;
   endtask

   task automatic push(input logic [31:0] addr, input logic we, input logic [3:0] strb, input logic [31:0] wdata,
                       input logic rdchk, input logic [31:0] rdexp);
      exp_t e;
      e.addr = addr; e.we = we; e.strb = strb; e.wdata = wdata; e.rdchk = rdchk; e.rdexp = rdexp;
      sb.push_back(e);
   endtask

   // One-cycle memory op against a zero-wait memory; the bus side is checked by the monitor.
   task automatic run_op(input string tag, input logic mr, input logic mw, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] strb, input logic [31:0] wdata, input logic [31:0] rdexp);
      step();
      dmem_ready = 1'b1;
      drive(mr, mw, f3, a, wd);
      push({a[31:2], 2'b00}, mw, strb, wdata, mr, rdexp);
      step();
      bubble();
      @(negedge clk);
      chk({tag, "_stall"}, StallMem, 1'b0);
   endtask

   always @(negedge clk) begin
      if (rst_n && dmem_req && dmem_ready) begin
         if (sb.size() == 0) chk("sb_extra_req", dmem_req, 1'b0);
         else begin
            exp_t e;
            e = sb.pop_front();
            chk("bus_addr", dmem_addr, e.addr);
            chk("bus_we", dmem_we, e.we);
            chk("bus_wstrb", dmem_wstrb, e.strb);
            if (e.we) chk("bus_wdata", dmem_wdata, e.wdata);
            if (e.rdchk) chk("ld_data", ReadDataM, e.rdexp);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_req", dmem_req, 1'b0);
      chk("rst_stall", StallMem, 1'b0);
      chk("rst_alu", ALUResultM, 32'h0);
      chk("rst_rdata", ReadDataM, 32'h0);
      chk("rst_rw", RegWriteM, 1'b0);
      rst_n = 1'b1;

      run_op("sw", 1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF, 32'h0);
      chk("sw_pc4", PCPlus4M, 32'h104);
      run_op("sb", 1'b0, 1'b1, 3'b000, 32'h103, 32'h000000A5, 4'b1000, 32'hA5A5A5A5, 32'h0);
      run_op("sh", 1'b0, 1'b1, 3'b001, 32'h102, 32'h00001234, 4'b1100, 32'h12341234, 32'h0);

      step();
      dmem_ready = 1'b0;
      dmem_rdata = 32'h0080FF00;
      drive(1'b1, 1'b0, 3'b000, 32'h102, 32'h0);
      push(32'h100, 1'b0, 4'b0000, 32'h0, 1'b1, 32'hFFFFFF80);
      step();
      bubble();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("lb_stall", StallMem, 1'b1);
         chk("lb_addr", dmem_addr, 32'h100);
         chk("lb_wstrb", dmem_wstrb, 4'b0000);
         @(posedge clk);
      end
      #1 dmem_ready = 1'b1;
      @(negedge clk);
      chk("lb_stall_end", StallMem, 1'b0);
      run_op("lbu", 1'b1, 1'b0, 3'b100, 32'h102, 32'h0, 4'b0000, 32'h0, 32'h00000080);
      chk("lbu_rd", RdM, 5'd3);
      chk("lbu_rs", ResultSrcM, 2'd1);
      run_op("lh", 1'b1, 1'b0, 3'b001, 32'h100, 32'h0, 4'b0000, 32'h0, 32'hFFFFFF00);
      run_op("lhu", 1'b1, 1'b0, 3'b101, 32'h100, 32'h0, 4'b0000, 32'h0, 32'h0000FF00);
      run_op("lw110", 1'b1, 1'b0, 3'b110, 32'h104, 32'h0, 4'b0000, 32'h0, 32'h0080FF00);

      step();
      FlushM = 1'b1;
      ALUResultE = 32'h77; RegWriteE = 1'b1; RdE = 5'd9;
      step();
      FlushM = 1'b0;
      bubble();
      @(negedge clk);
      chk("flush_rw", RegWriteM, 1'b0);
      chk("flush_alu", ALUResultM, 32'h0);
      chk("flush_rd", RdM, 5'd0);
      step();
      ALUResultE = 32'h77; RegWriteE = 1'b1; RdE = 5'd9;
      step();
      bubble();
      @(negedge clk);
      chk("alu_result", ALUResultM, 32'h77);
      chk("alu_rw", RegWriteM, 1'b1);
      chk("alu_rd", RdM, 5'd9);
      chk("alu_req", dmem_req, 1'b0);

      step();
      dmem_rdata = 32'h12345678;
      drive(1'b1, 1'b0, 3'b010, 32'h80, 32'h0);
      push(32'h80, 1'b0, 4'b0000, 32'h0, 1'b1, 32'h12345678);
      step();
      HoldM = 1'b1;
      FlushM = 1'b1;
      bubble();
      @(negedge clk);
      step();
      dmem_rdata = 32'hFFFFFFFF;
      @(negedge clk);
      chk("hold_req", dmem_req, 1'b0);
      chk("hold_stall", StallMem, 1'b0);
      chk("hold_rdata", ReadDataM, 32'h12345678);
      step();
      @(negedge clk);
      chk("hold_req2", dmem_req, 1'b0);
      chk("hold_rdata2", ReadDataM, 32'h12345678);
      chk("hold_rd", RdM, 5'd3);
      chk("hold_alu", ALUResultM, 32'h80);
      #1;
      HoldM = 1'b0;
      FlushM = 1'b0;
      ALUResultE = 32'h55; RegWriteE = 1'b1; RdE = 5'd7;
      step();
      bubble();
      @(negedge clk);
      chk("release_alu", ALUResultM, 32'h55);
      chk("release_rd", RdM, 5'd7);
      chk("release_rdata", ReadDataM, 32'h0);
      chk("release_req", dmem_req, 1'b0);

      step();
      dmem_ready = 1'b0;
      drive(1'b1, 1'b0, 3'b010, 32'h200, 32'h0);
      step();
      bubble();
      @(negedge clk);
      chk("busy_req", dmem_req, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_req", dmem_req, 1'b0);
      chk("arst_stall", StallMem, 1'b0);
      chk("arst_alu", ALUResultM, 32'h0);
      chk("arst_rd", RdM, 5'd0);
      chk("arst_pc4", PCPlus4M, 32'h0);
      chk("arst_addr", dmem_addr, 32'h0);
      chk("arst_rdata", ReadDataM, 32'h0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      run_op("sw_after_rst", 1'b0, 1'b1, 3'b010, 32'h300, 32'h11223344, 4'b1111, 32'h11223344, 32'h0);

`ifdef LSU_MISALIGN_TRAP_EN
      step();
      dmem_ready = 1'b1;
      drive(1'b1, 1'b0, 3'b001, 32'h101, 32'h0);
      step();
      bubble();
      @(negedge clk);
      chk("lh_mis_fault", misaligned_fault, 1'b1);
      chk("lh_mis_req", dmem_req, 1'b0);
      chk("lh_mis_stall", StallMem, 1'b0);
      chk("lh_mis_rw", RegWriteM, 1'b0);
`else
      dmem_rdata = 32'hAAAA8001;
      run_op("lh_mis", 1'b1, 1'b0, 3'b001, 32'h101, 32'h0, 4'b0000, 32'h0, 32'hFFFF8001);
      chk("lh_mis_fault", misaligned_fault, 1'b0);
      chk("lh_mis_rw", RegWriteM, 1'b1);
      run_op("sw_mis", 1'b0, 1'b1, 3'b010, 32'h102, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D, 32'h0);
      chk("sw_mis_fault", misaligned_fault, 1'b0);
`endif

      step();
      chk("sb_empty", sb.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
Memory stage of the 5-stage RV32I pipeline, directly downstream of the execute stage. Contains the EX/MEM pipeline register and a load/store unit. The LSU drives a valid/ready data-memory bus and produces lane-aligned stores and sign/zero-extended loads. Provides ALUResultM for execute-stage forwarding and StallMem for the hazard unit.

Parameters:
XLEN, 32, datapath width (only 32 is supported)
ADDR_LSB, 2, number of address bits dropped for word addressing on the bus

Ports:
clk  in  1  pipeline clock
rst_n  in  1  asynchronous active-low reset
ALUResultE  in  32  effective address or ALU result from execute
WriteDataE  in  32  forwarded store data from execute
funct3E  in  3  load/store size and sign
MemReadE  in  1  load in execute
MemWriteE  in  1  store in execute
RegWriteE  in  1  register write enable
RdE  in  5  destination register
ResultSrcE  in  2  writeback mux select
PCPlus4E  in  32  link value for JAL/JALR
HoldM  in  1  external stall from the hazard unit; freezes the M register
FlushM  in  1  inserts a bubble into M on the next advancing edge
ALUResultM  out  32  registered ALU result, forwarding source
RegWriteM  out  1  registered write enable
RdM  out  5  registered destination register
ResultSrcM  out  2  registered writeback select
PCPlus4M  out  32  registered link value
ReadDataM  out  32  extended load data, valid when StallMem=0
StallMem  out  1  M stage is waiting on memory
dmem_req  out  1  bus request
dmem_we  out  1  bus write
dmem_addr  out  32  word-aligned address
dmem_wdata  out  32  lane-replicated store data
dmem_wstrb  out  4  byte strobes (zero on reads)
dmem_ready  in  1  bus accept/complete
dmem_rdata  in  32  read word, valid with dmem_ready
misaligned_fault  out  1  misaligned access flag

Behaviour:
- Reset (async, rst_n=0): every M register and every output is 0; state is IDLE; dmem_req drops immediately, including mid-transfer. No transfer is resumed after reset.
- M register advance: the M register loads the E inputs on a rising edge when StallMem=0 and HoldM=0. If FlushM=1 on that edge, it loads a bubble instead (all control bits 0, data 0). HoldM or StallMem freezes the register, and FlushM is ignored while frozen.
- memop = MemReadM | MemWriteM.
- FSM states:
  - IDLE: no transfer pending. If memop and the current access is not a fault, dmem_req=1 combinationally in the same cycle and the state is treated as BUSY.
  - BUSY: dmem_req=1. dmem_addr, dmem_we, dmem_wdata and dmem_wstrb are held stable until dmem_ready=1.
    - On req&ready with HoldM=0: the transfer completes, StallMem=0 that cycle, ReadDataM is taken from dmem_rdata, and the state goes to IDLE.
    - On req&ready with HoldM=1: the extended read data is latched into rdata_q and the state goes to DONE.
  - DONE: dmem_req=0, StallMem=0, ReadDataM=rdata_q. Leaves to IDLE on the edge where HoldM=0 (the M register advances).
- StallMem = memop & !fault & (state!=DONE) & !(dmem_req & dmem_ready). Zero-wait-state memory therefore never stalls.
- Address and lanes: dmem_addr = {ALUResultM[31:2],2'b00}; off = ALUResultM[1:0].
- Stores:
  - SB: strobe 4'b0001<<off; wdata = byte replicated x4.
  - SH: strobe 4'b0011<<off; wdata = half replicated x2.
  - SW: strobe 4'b1111.
- Loads:
  - LB/LBU select byte off; LH/LHU select half off[1].
  - LB and LH sign-extend; LBU and LHU zero-extend.
  - funct3 values 011, 110 and 111 are treated as LW.
- Misaligned: a word access with off!=0, or a half access with off[0]=1.
- Non-memory instructions pass through in one cycle with dmem_req=0.

Optional Feature:
LSU_MISALIGN_TRAP_EN
- Defined: a misaligned access issues no bus request and does not stall. misaligned_fault=1 for the cycle(s) the instruction is in M. RegWriteM is forced to 0 for that instruction.
- Undefined: misaligned_fault is tied to 0. The access proceeds with off forced aligned (off[0] cleared for halves, off cleared for words).

Test Plan:
- SW, ALUResultE=0x100, WriteDataE=0xDEADBEEF, dmem_ready=1 constantly -> dmem_addr=0x100, wstrb=1111, wdata=0xDEADBEEF; StallMem never asserts.
- SB to 0x103 with data 0x000000A5 -> wstrb=1000, wdata=0xA5A5A5A5.
- LB from 0x102, rdata=0x0080FF00, ready delayed 3 cycles -> StallMem high for 3 cycles; address and wstrb=0000 held stable; ReadDataM=0xFFFFFF80. LBU at the same address -> ReadDataM=0x00000080.
- LW completes with HoldM=1 -> state DONE, dmem_req=0, ReadDataM holds rdata across 2 held cycles, then M advances when HoldM=0.
- rst_n pulsed low during BUSY -> dmem_req=0 immediately; all outputs 0; the next instruction starts from IDLE.
- LH at 0x101: with LSU_MISALIGN_TRAP_EN -> fault=1, no request, RegWriteM=0; without the macro -> access issued with off=0 and fault=0.
